// File: rtl/lsu.sv
// rtl/lsu.sv - load/store unit between EX and MEM: valid/ack data-memory handshake, pipeline stall, load write-back
// Optional feature macro: LSU_SUBWORD_EN (byte/half loads and stores with lane steering and extension).
// Without it every access is a full word and funct3 is ignored.
module lsu #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            req_valid_i,
  input  logic            req_we_i,
  input  logic [2:0]      req_funct3_i,
  input  logic [XLEN-1:0] addr_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [4:0]      rd_i,
  output logic            stall_o,
  output logic            wb_valid_o,
  output logic [4:0]      wb_rd_o,
  output logic [XLEN-1:0] wb_data_o,
  output logic            misalign_o,
  output logic            mem_req_o,
  output logic            mem_we_o,
  output logic [XLEN-1:0] mem_addr_o,
  output logic [XLEN-1:0] mem_wdata_o,
  output logic [3:0]      mem_be_o,
  input  logic            mem_ack_i,
  input  logic [XLEN-1:0] mem_rdata_i
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state_q, state_d;
  logic            we_q;
  logic            misalign_q;
  logic [XLEN-1:0] rdata_q;
  logic            misalign_now;
  logic [XLEN-1:0] st_wdata;
  logic [3:0]      st_be;

`ifdef LSU_SUBWORD_EN
  logic [2:0]      funct3_q;
  logic [1:0]      addr_lo_q;
  logic [XLEN-1:0] lane_word;
`else
  logic            unused_funct3;
  assign unused_funct3 = ^req_funct3_i;
`endif

  // Alignment check on the incoming request; bytes are never misaligned
  always_comb begin
    misalign_now = |addr_i[1:0];
`ifdef LSU_SUBWORD_EN
    case (req_funct3_i[1:0])
      2'b00:   misalign_now = 1'b0;
      2'b01:   misalign_now = addr_i[0];
      default: misalign_now = |addr_i[1:0];
    endcase
`endif
  end

  // Store data lane steering and byte enables; loads always enable the full word
  always_comb begin
    st_wdata = wdata_i;
    st_be    = 4'b1111;
`ifdef LSU_SUBWORD_EN
    if (req_we_i) begin
      case (req_funct3_i[1:0])
        2'b00: begin
          st_wdata = {4{wdata_i[7:0]}};
          st_be    = 4'b0001 << addr_i[1:0];
        end
        2'b01: begin
          st_wdata = {2{wdata_i[15:0]}};
          st_be    = addr_i[1] ? 4'b1100 : 4'b0011;
        end
        default: begin
          st_wdata = wdata_i;
          st_be    = 4'b1111;
        end
      endcase
    end
`endif
  end

  // FSM state register
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next state and handshake/status outputs; DONE ignores req_valid_i because it still shows the finished op
  always_comb begin
    state_d    = state_q;
    stall_o    = 1'b0;
    mem_req_o  = 1'b0;
    wb_valid_o = 1'b0;
    misalign_o = 1'b0;
    case (state_q)
      IDLE: begin
        stall_o = req_valid_i;
        if (req_valid_i) state_d = misalign_now ? DONE : BUSY;
      end
      BUSY: begin
        stall_o   = 1'b1;
        mem_req_o = 1'b1;
        if (mem_ack_i) state_d = DONE;
      end
      DONE: begin
        wb_valid_o = !we_q && !misalign_q;
        misalign_o = misalign_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (!rst_n_i) stall_o = 1'b0;
  end

  // Request latch, registered memory-side outputs held through BUSY, and load-data capture on ack
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      we_q        <= 1'b0;
      misalign_q  <= 1'b0;
      rdata_q     <= '0;
      wb_rd_o     <= '0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      mem_be_o    <= '0;
`ifdef LSU_SUBWORD_EN
      funct3_q    <= '0;
      addr_lo_q   <= '0;
`endif
    end else begin
      if (state_q == IDLE && req_valid_i) begin
        we_q       <= req_we_i;
        misalign_q <= misalign_now;
        wb_rd_o    <= rd_i;
`ifdef LSU_SUBWORD_EN
        funct3_q   <= req_funct3_i;
        addr_lo_q  <= addr_i[1:0];
`endif
        if (!misalign_now) begin
          mem_we_o    <= req_we_i;
          mem_addr_o  <= {addr_i[XLEN-1:2], 2'b00};
          mem_wdata_o <= st_wdata;
          mem_be_o    <= st_be;
        end
      end
      if (state_q == BUSY && mem_ack_i) begin
        mem_we_o <= 1'b0;
        if (!we_q) rdata_q <= mem_rdata_i;
      end
    end
  end

`ifdef LSU_SUBWORD_EN
  // Shift the addressed byte/half down to bit 0, then sign- or zero-extend by funct3[2]
  always_comb begin
    lane_word = rdata_q >> {addr_lo_q, 3'b000};
    case (funct3_q[1:0])
      2'b00:   wb_data_o = funct3_q[2] ? {24'b0, lane_word[7:0]}
                                       : {{24{lane_word[7]}}, lane_word[7:0]};
      2'b01:   wb_data_o = funct3_q[2] ? {16'b0, lane_word[15:0]}
                                       : {{16{lane_word[15]}}, lane_word[15:0]};
      default: wb_data_o = rdata_q;
    endcase
  end
`else
  // Word-only build returns the captured word unchanged
  always_comb begin
    wb_data_o = rdata_q;
  end
`endif

endmodule

// File: tb/tb_lsu.sv
// tb/tb_lsu.sv - self-checking bench for lsu: directed vector table, reset/back-to-back sequences, random vs reference model
module tb_lsu;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        req_valid_i;
  logic        req_we_i;
  logic [2:0]  req_funct3_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic [4:0]  rd_i;
  logic        stall_o;
  logic        wb_valid_o;
  logic [4:0]  wb_rd_o;
  logic [31:0] wb_data_o;
  logic        misalign_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;

  int errors = 0;
  int checks = 0;

  lsu #(.XLEN(32)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .req_valid_i(req_valid_i), .req_we_i(req_we_i), .req_funct3_i(req_funct3_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .rd_i(rd_i),
    .stall_o(stall_o), .wb_valid_o(wb_valid_o), .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o),
    .misalign_o(misalign_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
    .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
    int          k;
    logic [31:0] rdata;
  } req_t;

  typedef struct {
    int          done;
    int          stall;
    int          req;
    int          mis;
    int          wb;
    logic [31:0] wb_data;
    logic [31:0] maddr;
    logic [3:0]  be;
    logic [31:0] mwdata;
    logic        mwe;
  } exp_t;

  typedef struct {
    int          done;
    int          stall;
    int          req;
    int          mis;
    int          wb;
    int          wb_cycle;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    logic [31:0] maddr;
    logic [3:0]  be;
    logic [31:0] mwdata;
    logic        mwe;
    logic        unstable;
  } obs_t;

  typedef struct {
    req_t r;
    exp_t e;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [4:0] rd, input int k,
                              input logic [31:0] rdata, input int done, input int stall,
                              input int req, input int mis, input int wb,
                              input logic [31:0] wbd, input logic [31:0] maddr,
                              input logic [3:0] be, input logic [31:0] mwd);
    vec_t v;
    v.r.we = we; v.r.f3 = f3; v.r.addr = addr; v.r.wdata = wdata;
    v.r.rd = rd; v.r.k = k; v.r.rdata = rdata;
    v.e.done = done; v.e.stall = stall; v.e.req = req; v.e.mis = mis; v.e.wb = wb;
    v.e.wb_data = wbd; v.e.maddr = maddr; v.e.be = be; v.e.mwdata = mwd; v.e.mwe = we;
    return v;
  endfunction

  // Reference: access size from funct3, misalignment by modulo, lanes by multiplication, extension by offset
  function automatic exp_t model(input req_t r);
    exp_t        e;
    int          sz;
    int          off;
    logic [31:0] lane;
    logic [31:0] v;
    sz = 4;
`ifdef LSU_SUBWORD_EN
    if (r.f3[1:0] == 2'b00) sz = 1;
    else if (r.f3[1:0] == 2'b01) sz = 2;
`endif
    off = int'(r.addr % 4);
    e = '{default: 0};
    if ((r.addr % sz) != 0) begin
      e.done = 1; e.stall = 1; e.mis = 1;
      return e;
    end
    e.done  = r.k + 1;
    e.stall = r.k + 1;
    e.req   = r.k;
    e.wb    = r.we ? 0 : 1;
    e.maddr = r.addr - (r.addr % 4);
    e.mwe   = r.we;
    e.be    = r.we ? 4'(((1 << sz) - 1) << off) : 4'hF;
    if (sz == 1)      e.mwdata = (r.wdata & 32'hFF) * 32'h01010101;
    else if (sz == 2) e.mwdata = (r.wdata & 32'hFFFF) * 32'h00010001;
    else              e.mwdata = r.wdata;
    lane = r.rdata >> (8 * off);
    if (sz == 1) begin
      v = lane & 32'hFF;
      if (!r.f3[2] && v >= 32'h80) v = v + 32'hFFFFFF00;
    end else if (sz == 2) begin
      v = lane & 32'hFFFF;
      if (!r.f3[2] && v >= 32'h8000) v = v + 32'hFFFF0000;
    end else begin
      v = r.rdata;
    end
    e.wb_data = e.wb ? v : 32'h0;
    return e;
  endfunction

  // Drive one request, hold req_valid_i until DONE is seen, ack in cycle k, record per-cycle observations
  task automatic run_txn(input req_t r, input bit idle_after, output obs_t o);
    bit done_seen;
    o = '{default: 0};
    o.done = -1;
    done_seen = 0;
    req_valid_i = 1'b1; req_we_i = r.we; req_funct3_i = r.f3;
    addr_i = r.addr; wdata_i = r.wdata; rd_i = r.rd;
    for (int cyc = 0; cyc < 60 && !done_seen; cyc++) begin
      mem_ack_i   = (cyc == r.k);
      mem_rdata_i = (cyc == r.k) ? r.rdata : $urandom;
      @(negedge clk_i);
      if (stall_o) o.stall++;
      if (mem_req_o) begin
        if (o.req == 0) begin
          o.maddr = mem_addr_o; o.be = mem_be_o; o.mwdata = mem_wdata_o; o.mwe = mem_we_o;
        end else if (mem_addr_o !== o.maddr || mem_be_o !== o.be ||
                     mem_wdata_o !== o.mwdata || mem_we_o !== o.mwe) begin
          o.unstable = 1'b1;
        end
        o.req++;
      end
      if (wb_valid_o) begin
        o.wb++; o.wb_data = wb_data_o; o.wb_rd = wb_rd_o; o.wb_cycle = cyc;
      end
      if (misalign_o) o.mis++;
      if (cyc > 0 && !stall_o) begin
        o.done = cyc;
        done_seen = 1;
      end
      @(posedge clk_i); #1;
    end
    req_valid_i = 1'b0;
    mem_ack_i   = 1'b0;
    if (idle_after) begin
      @(negedge clk_i);
      chk("idle_after.mem_req", 32'(mem_req_o), 32'h0);
      chk("idle_after.stall", 32'(stall_o), 32'h0);
      @(posedge clk_i); #1;
    end
  endtask

  task automatic compare(input string tag, input req_t r, input exp_t e, input obs_t o);
    chk({tag, ".done_cycle"}, 32'(o.done), 32'(e.done));
    chk({tag, ".stall_cycles"}, 32'(o.stall), 32'(e.stall));
    chk({tag, ".req_cycles"}, 32'(o.req), 32'(e.req));
    chk({tag, ".misalign_pulses"}, 32'(o.mis), 32'(e.mis));
    chk({tag, ".wb_pulses"}, 32'(o.wb), 32'(e.wb));
    if (e.wb != 0) begin
      chk({tag, ".wb_data"}, o.wb_data, e.wb_data);
      chk({tag, ".wb_rd"}, 32'(o.wb_rd), 32'(r.rd));
      chk({tag, ".wb_cycle"}, 32'(o.wb_cycle), 32'(e.done));
    end
    if (e.req != 0) begin
      chk({tag, ".mem_addr"}, o.maddr, e.maddr);
      chk({tag, ".mem_be"}, 32'(o.be), 32'(e.be));
      chk({tag, ".mem_we"}, 32'(o.mwe), 32'(e.mwe));
      chk({tag, ".mem_stable"}, 32'(o.unstable), 32'h0);
      if (r.we) chk({tag, ".mem_wdata"}, o.mwdata, e.mwdata);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, ".stall"}, 32'(stall_o), 32'h0);
    chk({tag, ".mem_req"}, 32'(mem_req_o), 32'h0);
    chk({tag, ".mem_we"}, 32'(mem_we_o), 32'h0);
    chk({tag, ".wb_valid"}, 32'(wb_valid_o), 32'h0);
    chk({tag, ".misalign"}, 32'(misalign_o), 32'h0);
    chk({tag, ".mem_addr"}, mem_addr_o, 32'h0);
    chk({tag, ".mem_wdata"}, mem_wdata_o, 32'h0);
    chk({tag, ".mem_be"}, 32'(mem_be_o), 32'h0);
    chk({tag, ".wb_rd"}, 32'(wb_rd_o), 32'h0);
    chk({tag, ".wb_data"}, wb_data_o, 32'h0);
  endtask

  initial begin
    vec_t vecs[$];
    obs_t o;
    req_t r;
    exp_t e;

    vecs.push_back(mk(0, 3'b010, 32'h100, 32'h0, 5'd5, 1, 32'hDEADBEEF,
                      2, 2, 1, 0, 1, 32'hDEADBEEF, 32'h100, 4'hF, 32'h0));
    vecs.push_back(mk(1, 3'b010, 32'h204, 32'h12345678, 5'd0, 4, 32'h0,
                      5, 5, 4, 0, 0, 32'h0, 32'h204, 4'hF, 32'h12345678));
    vecs.push_back(mk(0, 3'b010, 32'h102, 32'h0, 5'd3, 1, 32'h0,
                      1, 1, 0, 1, 0, 32'h0, 32'h0, 4'h0, 32'h0));
    vecs.push_back(mk(1, 3'b010, 32'h203, 32'h5, 5'd0, 1, 32'h0,
                      1, 1, 0, 1, 0, 32'h0, 32'h0, 4'h0, 32'h0));
    vecs.push_back(mk(0, 3'b010, 32'hFFFFFFFC, 32'h0, 5'd31, 3, 32'h00000001,
                      4, 4, 3, 0, 1, 32'h00000001, 32'hFFFFFFFC, 4'hF, 32'h0));
`ifdef LSU_SUBWORD_EN
    vecs.push_back(mk(0, 3'b000, 32'h103, 32'h0, 5'd9, 1, 32'h80FFFFFF,
                      2, 2, 1, 0, 1, 32'hFFFFFF80, 32'h100, 4'hF, 32'h0));
    vecs.push_back(mk(0, 3'b101, 32'h102, 32'h0, 5'd10, 2, 32'h8001AAAA,
                      3, 3, 2, 0, 1, 32'h00008001, 32'h100, 4'hF, 32'h0));
    vecs.push_back(mk(1, 3'b000, 32'h101, 32'h000000AB, 5'd0, 1, 32'h0,
                      2, 2, 1, 0, 0, 32'h0, 32'h100, 4'b0010, 32'hABABABAB));
    vecs.push_back(mk(1, 3'b001, 32'h102, 32'h1234CDEF, 5'd0, 1, 32'h0,
                      2, 2, 1, 0, 0, 32'h0, 32'h100, 4'b1100, 32'hCDEFCDEF));
    vecs.push_back(mk(0, 3'b100, 32'h102, 32'h0, 5'd11, 1, 32'h11228833,
                      2, 2, 1, 0, 1, 32'h00000022, 32'h100, 4'hF, 32'h0));
    vecs.push_back(mk(0, 3'b001, 32'h101, 32'h0, 5'd12, 1, 32'h0,
                      1, 1, 0, 1, 0, 32'h0, 32'h0, 4'h0, 32'h0));
`else
    vecs.push_back(mk(0, 3'b000, 32'h103, 32'h0, 5'd9, 1, 32'h80FFFFFF,
                      1, 1, 0, 1, 0, 32'h0, 32'h0, 4'h0, 32'h0));
    vecs.push_back(mk(0, 3'b001, 32'h100, 32'h0, 5'd10, 1, 32'h8001AAAA,
                      2, 2, 1, 0, 1, 32'h8001AAAA, 32'h100, 4'hF, 32'h0));
    vecs.push_back(mk(1, 3'b000, 32'h100, 32'h000000AB, 5'd0, 1, 32'h0,
                      2, 2, 1, 0, 0, 32'h0, 32'h100, 4'hF, 32'h000000AB));
`endif

    rst_n_i = 1'b0; req_valid_i = 1'b1; req_we_i = 1'b0; req_funct3_i = 3'b010;
    addr_i = 32'h0; wdata_i = 32'h0; rd_i = 5'd0; mem_ack_i = 1'b0; mem_rdata_i = 32'h0;
    repeat (3) @(posedge clk_i);
    #1;
    @(negedge clk_i);
    check_reset_vals("reset");
    @(posedge clk_i); #1;
    rst_n_i = 1'b1; req_valid_i = 1'b0;
    @(posedge clk_i); #1;

    foreach (vecs[i]) begin
      run_txn(vecs[i].r, 1'b1, o);
      compare($sformatf("vec%0d", i), vecs[i].r, vecs[i].e, o);
    end

    // Back-to-back: SW presented in the cycle right after LW's DONE
    begin
      vec_t lw, sw;
      lw = mk(0, 3'b010, 32'h400, 32'h0, 5'd4, 2, 32'hCAFEF00D,
              3, 3, 2, 0, 1, 32'hCAFEF00D, 32'h400, 4'hF, 32'h0);
      sw = mk(1, 3'b010, 32'h408, 32'h0BADBEEF, 5'd6, 1, 32'h0,
              2, 2, 1, 0, 0, 32'h0, 32'h408, 4'hF, 32'h0BADBEEF);
      run_txn(lw.r, 1'b0, o);
      compare("b2b_lw", lw.r, lw.e, o);
      run_txn(sw.r, 1'b1, o);
      compare("b2b_sw", sw.r, sw.e, o);
    end

    // Reset during BUSY, then a late ack while idle
    req_valid_i = 1'b1; req_we_i = 1'b0; req_funct3_i = 3'b010;
    addr_i = 32'h300; wdata_i = 32'h0; rd_i = 5'd7;
    @(posedge clk_i); #1;
    @(negedge clk_i);
    chk("rst_mid.busy_req", 32'(mem_req_o), 32'h1);
    @(posedge clk_i); #1;
    rst_n_i = 1'b0;
    @(negedge clk_i);
    chk("rst_mid.stall_forced", 32'(stall_o), 32'h0);
    @(posedge clk_i); #1;
    @(negedge clk_i);
    check_reset_vals("rst_mid");
    @(posedge clk_i); #1;
    rst_n_i = 1'b1; req_valid_i = 1'b0; mem_ack_i = 1'b1; mem_rdata_i = 32'h55AA55AA;
    @(negedge clk_i);
    chk("late_ack.wb_valid", 32'(wb_valid_o), 32'h0);
    chk("late_ack.mem_req", 32'(mem_req_o), 32'h0);
    @(posedge clk_i); #1;
    mem_ack_i = 1'b0;
    @(negedge clk_i);
    chk("late_ack.wb_valid_next", 32'(wb_valid_o), 32'h0);
    chk("late_ack.stall", 32'(stall_o), 32'h0);
    @(posedge clk_i); #1;

    // Random transactions against the reference model
    for (int n = 0; n < 60; n++) begin
      r.we = 1'($urandom_range(0, 1));
`ifdef LSU_SUBWORD_EN
      if (r.we) r.f3 = 3'($urandom_range(0, 2));
      else begin
        case ($urandom_range(0, 4))
          0: r.f3 = 3'b000;
          1: r.f3 = 3'b001;
          2: r.f3 = 3'b010;
          3: r.f3 = 3'b100;
          default: r.f3 = 3'b101;
        endcase
      end
`else
      r.f3 = 3'($urandom_range(0, 7));
`endif
      r.addr = $urandom & 32'h0000FFFF;
      if ($urandom_range(0, 1) == 1) r.addr = r.addr & 32'hFFFFFFFC;
      r.wdata = $urandom;
      r.rd    = 5'($urandom_range(0, 31));
      r.k     = $urandom_range(1, 4);
      r.rdata = $urandom;
      e = model(r);
      run_txn(r, 1'($urandom_range(0, 1)), o);
      compare($sformatf("rand%0d", n), r, e, o);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit in the EX→MEM boundary of the RISC-V core. Consumes the ALU's computed effective address (ADD result for LW/SW) plus the store operand, runs a valid/ack handshake with data memory, stalls the pipeline while the access is outstanding, and returns load data for write-back. Detects misaligned accesses and reports them without touching memory.

## Interface
- `XLEN`, 32: data/address width; only 32 is supported.
- `clk_i` input 1: clock, rising edge.
- `rst_n_i` input 1: reset. Synchronous and active-low: sampled on the rising edge of `clk_i`, reset when low.
- `req_valid_i` input 1: EX stage holds a memory instruction.
- `req_we_i` input 1: 1 = store, 0 = load.
- `req_funct3_i` input 3: instruction funct3.
- `addr_i` input 32: effective address from the ALU `data_o`.
- `wdata_i` input 32: rs2 value for stores.
- `rd_i` input 5: load destination register.
- `stall_o` output 1: freeze PC and all upstream pipeline registers.
- `wb_valid_o` output 1: load result valid, one-cycle pulse.
- `wb_rd_o` output 5: load destination.
- `wb_data_o` output 32: extended load data.
- `misalign_o` output 1: misaligned-access pulse.
- `mem_req_o` output 1: memory request.
- `mem_we_o` output 1: memory write.
- `mem_addr_o` output 32: word address, with bits [1:0] = 0.
- `mem_wdata_o` output 32: lane-aligned store data.
- `mem_be_o` output 4: byte enables.
- `mem_ack_i` input 1: memory completion.
- `mem_rdata_i` input 32: read word; valid in the cycle `mem_ack_i` is high.

## Operation
- FSM states: IDLE, BUSY, DONE. Reset → IDLE.
- **IDLE**
  - If `req_valid_i`=1, latch `addr_i`, `wdata_i`, `req_we_i`, `req_funct3_i`, `rd_i`.
  - Aligned access → BUSY. Misaligned → DONE with the misalign flag set.
- **BUSY**
  - `mem_req_o`=1. `mem_we_o`, `mem_addr_o`, `mem_wdata_o` and `mem_be_o` are registered and held stable until `mem_ack_i` is sampled high.
  - On ack: capture `mem_rdata_i` for loads, → DONE.
- **DONE** (one cycle)
  - `wb_valid_o`=1 for a completed load. `misalign_o`=1 if flagged.
  - → IDLE.
  - `req_valid_i` is ignored in this cycle: it still reflects the finished instruction.
- **Alignment**
  - Word: `addr[1:0]`≠0 is misaligned.
  - Half (with the configuration macro): `addr[0]`≠0 is misaligned.
  - Byte accesses are never misaligned.
  - A misaligned access issues no memory request and no write-back.
- **Loads**: `wb_data_o` is built from the captured word and the latched funct3/`addr[1:0]`.
- **Reset mid-operation**
  - The FSM goes to IDLE and `mem_req_o` drops on the next edge.
  - A late `mem_ack_i` arriving in IDLE is ignored.
- Stores never assert `wb_valid_o`.

## Timing
- **Reset values**: `mem_req_o`, `mem_we_o`, `wb_valid_o` and `misalign_o` = 0. All data, address, `rd` and byte-enable outputs = 0.
- **`stall_o`**: combinational.
  - Equals `req_valid_i` in IDLE, 1 in BUSY, 0 in DONE.
  - Forced to 0 while `rst_n_i`=0.
- **Aligned access**, request seen at cycle 0:
  - `mem_req_o` is high from cycle 1.
  - Ack may arrive at any cycle k≥1, including cycle 1.
  - DONE (and `wb_valid_o`) at cycle k+1.
  - `stall_o` is high for cycles 0..k.
  - Minimum occupancy is 3 cycles, of which 2 are stalled.
- **Misaligned access**: DONE at cycle 1 with `misalign_o`=1. `stall_o` is high for cycle 0 only.
- The next request can be accepted in the cycle after DONE.

## Configuration
- `LSU_SUBWORD_EN` defined:
  - Supports LB/LH/LW/LBU/LHU (funct3 000/001/010/100/101) and SB/SH/SW (000/001/010).
  - Store data is replicated into the lanes: byte ×4, half ×2.
  - `mem_be_o` selects the addressed lane(s).
  - Loads shift down the addressed byte/half, then sign- or zero-extend.
  - `mem_be_o`=4'b1111 for loads.
- Undefined:
  - Every access is treated as a word regardless of funct3.
  - `mem_be_o`=4'b1111 always, `mem_wdata_o`=`wdata_i`, `wb_data_o`=read word.
  - Misalignment is checked on `addr[1:0]` only.

## Test plan
- **LW, immediate ack**: LW `addr`=0x100, `rd`=5, ack at cycle 1 with 0xDEADBEEF.
  - Required: `mem_addr_o`=0x100, `stall_o` high for 2 cycles.
  - Required: at cycle 2, `wb_valid_o`=1, `wb_rd_o`=5, `wb_data_o`=0xDEADBEEF.
- **SW, delayed ack**: SW `addr`=0x204, data 0x12345678, ack delayed to cycle 4.
  - Required: `mem_req_o`/`mem_we_o` high with stable outputs for cycles 1–4, `mem_be_o`=4'b1111.
  - Required: `stall_o` high for cycles 0–4, `wb_valid_o` never asserted.
- **Misaligned LW**: LW `addr`=0x102.
  - Required: no `mem_req_o`, `misalign_o`=1 at cycle 1, `stall_o` high for cycle 0 only.
- **Reset mid-access**: reset asserted during BUSY, then a late ack.
  - Required: `mem_req_o`=0 after the edge and all outputs at reset values.
  - Required: the late ack causes no `wb_valid_o`.
- **Sub-word, `LSU_SUBWORD_EN` only**:
  - LB `addr`=0x103 with word 0x80FFFFFF → `wb_data_o`=0xFFFFFF80.
  - LHU `addr`=0x102 with word 0x8001AAAA → `wb_data_o`=0x00008001.
  - SB `addr`=0x101 with data 0xAB → `mem_be_o`=4'b0010, `mem_wdata_o`=0xABABABAB.
- **Back-to-back**: LW followed immediately by SW.
  - Required: SW accepted in the cycle after LW's DONE.
  - Required: LW's `req_valid_i` still high during DONE is not re-issued.
